hdmi_line_prefetch: RTL and testbench
=====================================

# hdmi_line_prefetch

Line-prefetch DRAM read scheduler for the HDMI scan-out path. It sits directly upstream of the scan-out pixel FIFO. It turns the display timing's per-line prefetch pulses into bursted DRAM read commands (`kick`/`read_addr`/`read_num`) for the DRAM read engine, whose data lands in the pixel FIFO. Issue is throttled on FIFO occupancy so the FIFO never overflows, and the read pointer is restarted on every frame start.

## Interface
Parameters:
- `X_SIZE`, 1600: pixels (32-bit words) per line.
- `Y_SIZE`, 900: lines per frame.
- `STRIDE`, 6400: bytes between line starts.
- `BURST`, 256: maximum words per read command (1..255 ... 4096).
- `FIFO_DEPTH`, 4096: pixel FIFO capacity in words.
- `FB_BASE0`, 32'h0000_0000: byte base of frame buffer 0.
- `FB_BASE1`, 32'h0080_0000: byte base of frame buffer 1 (double-buffer builds only).

Ports:
- `clk` in 1: DRAM-side clock; all logic is on this clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse, already synchronised to `clk`.
- `prefetch_line` in 1: one-cycle pulse requesting the next line, already synchronised.
- `fifo_available` in 32: words written to the FIFO but not yet read; interpreted as signed.
- `kick` out 1: read command valid.
- `busy` in 1: read engine busy; `kick && busy` means the command is accepted.
- `read_addr` out 32: byte address of the command.
- `read_num` out 32: word count of the command.
- `swap_req` in 1: pulse requesting a buffer flip at the next `frame_start`.
- `fb_sel` out 1: active frame buffer.
- `frame_fetched` out 1: one-cycle pulse when the final chunk of line `Y_SIZE-1` completes.

## Operation
- Reset values: `kick`=0, `read_addr`=0, `read_num`=0, `fb_sel`=0, `frame_fetched`=0. State is IDLE; `pending`, `line`, `word` and the buffer flip latch are 0.
- `pending`: 2-bit count of unserved line requests.
  - `prefetch_line` increments it, saturating at 3.
  - Starting a line decrements it.
  - Requests that arrive once `line`==`Y_SIZE` are dropped.
- `frame_start` behaviour:
  - Clears `pending`, `line` and `word`.
  - If `prefetch_line` arrives in the same cycle, `frame_start` is applied first, then the request counts, so `pending`=1.
  - From KICK (command not yet accepted): `kick` drops next cycle and the state goes to IDLE.
  - From WAIT_DONE: the block stays there until `busy`=0, then goes to IDLE. The new frame starts only after that.
- States:
  - IDLE: if `pending`>0 and `line`<`Y_SIZE`, decrement `pending`, set `word`=0, go to SPACE.
  - SPACE: `chunk` = min(`BURST`, `X_SIZE`-`word`). Let `avail` = max(`fifo_available`, 0). When `avail` + `chunk` <= `FIFO_DEPTH`, load `read_addr` and `read_num`=`chunk` and go to KICK.
  - KICK: `kick`=1. When `busy`=1, the command is accepted: `word` += `chunk`, go to WAIT_DONE.
  - WAIT_DONE: wait for `busy`=0.
    - If `word`<`X_SIZE`, go to SPACE.
    - Otherwise `line`++. If the new `line`==`Y_SIZE`, pulse `frame_fetched`. Go to IDLE.
- Address: `read_addr` = base + `line`*`STRIDE` + `word`*4, computed at 32-bit width with wrap-around.
  - base is `FB_BASE0`, or `FB_BASE1` when `fb_sel`=1.
- For the defaults, one line is 6 commands of 256 words followed by one of 64.

## Timing
- `prefetch_line` at cycle N gives IDLE→SPACE at N+1.
  - If space is available, `kick`=1 from N+2.
- `read_addr` and `read_num` are stable for the whole time `kick`=1.
- `kick` falls the cycle after `kick && busy`. The block issues at most one command per acceptance.
- A `busy` that is already high on entry to KICK counts as acceptance in that cycle.
- The space check uses the registered `fifo_available` of the SPACE cycle.
- `frame_fetched` is asserted in the cycle after the final WAIT_DONE exit.

## Configuration
- Macro: `HDMI_PREFETCH_DOUBLE_BUFFER_EN`.
- With the macro defined:
  - A `swap_req` pulse sets the flip latch.
  - On `frame_start`, if the latch is set, `fb_sel` toggles and the latch clears.
  - If `swap_req` and `frame_start` coincide, the flip happens at that `frame_start`.
- Without the macro: `swap_req` is ignored, `fb_sel` is constant 0, and the base is always `FB_BASE0`.

## Test plan
- Buffer space:
  - Stimulus: after reset, `frame_start`, then `prefetch_line`; `fifo_available`=0; `busy` rises 1 cycle after `kick` and stays high 4 cycles.
  - Required: 7 commands with `read_addr`=0, 0x400, …, 0x1800 and `read_num`=256×6 then 64.
- Throttle:
  - Stimulus: `fifo_available`=3900.
  - Required: no `kick` until `fifo_available`<=3840; then `read_num`=256.
- Second line and overflow:
  - Stimulus: second `prefetch_line`.
  - Required: first command `read_addr`=6400.
  - Stimulus: four queued pulses.
  - Required: only 3 lines are fetched.
- Frame end:
  - Stimulus: 900 lines fetched.
  - Required: exactly one `frame_fetched` pulse; a further `prefetch_line` is ignored.
- Frame start mid-burst:
  - Stimulus: `frame_start` while in KICK with `busy`=0.
  - Required: `kick` low the next cycle; the next command has `read_addr`=base.
- Buffer flip (macro defined):
  - Stimulus: `swap_req`, then `frame_start`, then `prefetch_line`.
  - Required: `fb_sel`=1 and first `read_addr`=0x0080_0000.
  - Without the macro, the same stimulus gives `read_addr`=0.

Source files
------------

// File: rtl/hdmi_line_prefetch_if.sv
// Read-command handshake between the line prefetcher and the DRAM read engine.
// kick is held with stable addr/num until the engine answers with busy.
interface hdmi_line_prefetch_if;
  logic        kick;
  logic        busy;
  logic [31:0] read_addr;
  logic [31:0] read_num;

  modport master (
    output kick,
    output read_addr,
    output read_num,
    input  busy
  );

  modport slave (
    input  kick,
    input  read_addr,
    input  read_num,
    output busy
  );
endinterface

// File: rtl/hdmi_line_prefetch.sv
// Per-line DRAM read scheduler feeding the HDMI scan-out pixel FIFO.
// HDMI_PREFETCH_DOUBLE_BUFFER_EN enables swap_req / fb_sel buffer flipping.
module hdmi_line_prefetch #(
  parameter int          X_SIZE     = 1600,
  parameter int          Y_SIZE     = 900,
  parameter int          STRIDE     = 6400,
  parameter int          BURST      = 256,
  parameter int          FIFO_DEPTH = 4096,
  parameter logic [31:0] FB_BASE0   = 32'h0000_0000,
  parameter logic [31:0] FB_BASE1   = 32'h0080_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        prefetch_line,
  input  logic [31:0]                 fifo_available,
  hdmi_line_prefetch_if.master        rd,
  input  logic                        swap_req,
  output logic                        fb_sel,
  output logic                        frame_fetched
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPACE,
    S_KICK,
    S_WAIT
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_pend, w_pend;
  logic [2:0]  w_psum;
  logic [31:0] r_line, r_word, r_addr, r_num;
  logic        r_abort, r_ff;
  logic [31:0] w_rem, w_chunk, w_avail, w_base, w_addr;
  logic [32:0] w_need;
  logic        w_req, w_start, w_fits, w_accept;
  logic        w_done, w_abort, w_line_end;

  assign w_rem   = 32'(X_SIZE) - r_word;
  assign w_chunk = (w_rem < 32'(BURST)) ? w_rem : 32'(BURST);
  // negative occupancy is treated as an empty FIFO
  assign w_avail = fifo_available[31] ? '0 : fifo_available;
  assign w_need  = {1'b0, w_avail} + {1'b0, w_chunk};
  assign w_fits  = w_need <= 33'(FIFO_DEPTH);
  assign w_base  = fb_sel ? FB_BASE1 : FB_BASE0;
  assign w_addr  = w_base + r_line * 32'(STRIDE) + (r_word << 2);

  assign w_req    = prefetch_line &&
                    (frame_start || r_line < 32'(Y_SIZE));
  assign w_start  = (r_state == S_IDLE) && !frame_start &&
                    (r_line < 32'(Y_SIZE)) &&
                    ((r_pend != 2'd0) || w_req);
  assign w_accept = (r_state == S_KICK) && rd.busy;
  assign w_done   = (r_state == S_WAIT) && !rd.busy;
  assign w_abort  = r_abort || frame_start;
  assign w_line_end = w_done && !w_abort &&
                      (r_word >= 32'(X_SIZE));

  assign w_psum = {1'b0, r_pend} - {2'b0, w_start} + {2'b0, w_req};

  always_comb begin
    w_pend = r_pend;
    if (frame_start)
      w_pend = {1'b0, w_req};
    else if (w_psum > 3'd3)
      w_pend = 2'd3;
    else
      w_pend = w_psum[1:0];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_SPACE;
      S_SPACE: begin
        if (frame_start)  w_next = S_IDLE;
        else if (w_fits)  w_next = S_KICK;
      end
      S_KICK: begin
        if (rd.busy)          w_next = S_WAIT;
        else if (frame_start) w_next = S_IDLE;
      end
      S_WAIT: begin
        if (!rd.busy) begin
          if (w_abort)                    w_next = S_IDLE;
          else if (r_word < 32'(X_SIZE))  w_next = S_SPACE;
          else                            w_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= 2'd0;
      r_line  <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_num   <= '0;
      r_abort <= 1'b0;
      r_ff    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend;
      if (frame_start)     r_line <= '0;
      else if (w_line_end) r_line <= r_line + 32'd1;
      if (frame_start || w_start) r_word <= '0;
      else if (w_accept)          r_word <= r_word + r_num;
      if (r_state == S_SPACE && !frame_start && w_fits) begin
        r_addr <= w_addr;
        r_num  <= w_chunk;
      end
      // an in-flight command must drain before the new frame begins
      if (w_done)
        r_abort <= 1'b0;
      else if (frame_start && (r_state == S_WAIT || w_accept))
        r_abort <= 1'b1;
      r_ff <= w_line_end && (r_line + 32'd1 == 32'(Y_SIZE));
    end
  end

`ifdef HDMI_PREFETCH_DOUBLE_BUFFER_EN
  logic r_swap, r_fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap <= 1'b0;
      r_fb   <= 1'b0;
    end else if (frame_start && (r_swap || swap_req)) begin
      r_swap <= 1'b0;
      r_fb   <= ~r_fb;
    end else if (swap_req) begin
      r_swap <= 1'b1;
    end
  end

  assign fb_sel = r_fb;
`else
  logic w_unused_swap;
  assign w_unused_swap = swap_req;
  assign fb_sel        = 1'b0;
`endif

  assign rd.kick      = (r_state == S_KICK);
  assign rd.read_addr = r_addr;
  assign rd.read_num  = r_num;
  assign frame_fetched = r_ff;

endmodule

// File: tb/tb_hdmi_line_prefetch.sv
// Directed bench for hdmi_line_prefetch with a command scoreboard
// and a simple busy-responding read-engine model.
module tb_hdmi_line_prefetch;
  localparam int          X   = 1600;
  localparam int          Y   = 900;
  localparam int          STR = 6400;
  localparam int          BST = 256;
  localparam int          DEP = 4096;
  localparam logic [31:0] B0  = 32'h0000_0000;
  localparam logic [31:0] B1  = 32'h0080_0000;
`ifdef HDMI_PREFETCH_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        prefetch_line = 1'b0;
  logic        swap_req = 1'b0;
  logic [31:0] fifo_available = 32'd0;
  logic        fb_sel;
  logic        frame_fetched;

  hdmi_line_prefetch_if rd_if();

  hdmi_line_prefetch #(
    .X_SIZE(X), .Y_SIZE(Y), .STRIDE(STR), .BURST(BST),
    .FIFO_DEPTH(DEP), .FB_BASE0(B0), .FB_BASE1(B1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .prefetch_line(prefetch_line),
    .fifo_available(fifo_available),
    .rd(rd_if),
    .swap_req(swap_req),
    .fb_sel(fb_sel),
    .frame_fetched(frame_fetched)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_cmd   = 0;
  int          ff_cnt  = 0;
  logic [63:0] sb[$];
  bit          eng_en   = 1'b1;
  int          eng_lat  = 1;
  int          eng_hold = 4;
  int          arm  = 0;
  int          bcnt = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // engine model and scoreboard; busy here is what the DUT sees next edge
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst || !eng_en) begin
      rd_if.busy = 1'b0;
      arm = 0;
      bcnt = 0;
    end else if (rd_if.busy) begin
      bcnt--;
      if (bcnt <= 0) rd_if.busy = 1'b0;
    end else if (rd_if.kick) begin
      if (arm >= eng_lat) begin
        rd_if.busy = 1'b1;
        bcnt = eng_hold;
        arm = 0;
      end else begin
        arm++;
      end
    end
    if (!rst && rd_if.kick && rd_if.busy) begin
      n_cmd++;
      chk("cmd_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("cmd", {rd_if.read_addr, rd_if.read_num}, e);
      end
    end
    if (frame_fetched === 1'b1) ff_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(int n);
    repeat (n) step();
  endtask

  task automatic pulse_prefetch();
    prefetch_line = 1'b1;
    step();
    prefetch_line = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic push_line(logic [31:0] base, int line);
    for (int w = 0; w < X; w += BST) begin
      logic [31:0] a;
      logic [31:0] n;
      a = base + 32'(line * STR) + 32'(w * 4);
      n = 32'((X - w < BST) ? X - w : BST);
      sb.push_back({a, n});
    end
  endtask

  task automatic drain(string tag, int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) step();
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    wait_n(3);
    chk("rst_kick", rd_if.kick, 0);
    chk("rst_addr", rd_if.read_addr, 0);
    chk("rst_num", rd_if.read_num, 0);
    chk("rst_fb_sel", fb_sel, 0);
    chk("rst_frame_fetched", frame_fetched, 0);
    rst = 1'b0;
    step();

    // line 0: 6 x 256 + 64, prefetch at N gives kick at N+2
    pulse_fs();
    push_line(B0, 0);
    prefetch_line = 1'b1;
    step();
    prefetch_line = 1'b0;
    chk("space_cycle_kick", rd_if.kick, 0);
    step();
    chk("kick_at_n2", rd_if.kick, 1);
    drain("line0", 400);
    wait_n(10);

    // throttle on occupancy, boundary at 4096-256
    fifo_available = 32'd3900;
    push_line(B0, 1);
    pulse_prefetch();
    wait_n(20);
    chk("throttle_hold_q", 64'(sb.size()), 64'd7);
    chk("throttle_hold_kick", rd_if.kick, 0);
    fifo_available = 32'd3841;
    wait_n(10);
    chk("throttle_3841_kick", rd_if.kick, 0);
    fifo_available = 32'd3840;
    drain("line1", 600);
    wait_n(10);

    // pending saturates at 3 behind a stalled line
    fifo_available = 32'd4096;
    for (int l = 2; l < 6; l++) push_line(B0, l);
    pulse_prefetch();
    prefetch_line = 1'b1;
    wait_n(4);
    prefetch_line = 1'b0;
    wait_n(5);
    chk("full_fifo_kick", rd_if.kick, 0);
    c0 = n_cmd;
    fifo_available = 32'hFFFF_FF9C;
    drain("overflow", 2000);
    wait_n(100);
    chk("overflow_cmds", 64'(n_cmd - c0), 64'd28);
    fifo_available = 32'd0;

    // frame_start while kick waits for an engine that never answers
    eng_en = 1'b0;
    pulse_prefetch();
    step();
    chk("mid_kick", rd_if.kick, 1);
    chk("mid_addr", rd_if.read_addr, 6 * STR);
    chk("mid_num", rd_if.read_num, BST);
    wait_n(3);
    chk("mid_kick_hold", rd_if.kick, 1);
    pulse_fs();
    chk("fs_kick_drop", rd_if.kick, 0);
    eng_en = 1'b1;
    push_line(B0, 0);
    pulse_prefetch();
    drain("restart", 400);
    wait_n(10);

    // full frame with a fast engine
    eng_lat = 0;
    eng_hold = 1;
    pulse_fs();
    ff_cnt = 0;
    for (int l = 0; l < Y; l++) begin
      push_line(B0, l);
      pulse_prefetch();
      drain("frame", 200);
    end
    wait_n(5);
    chk("frame_fetched_cnt", 64'(ff_cnt), 64'd1);
    c0 = n_cmd;
    pulse_prefetch();
    wait_n(30);
    chk("post_frame_cmds", 64'(n_cmd - c0), 64'd0);
    chk("post_frame_kick", rd_if.kick, 0);
    chk("post_frame_ff_cnt", 64'(ff_cnt), 64'd1);

    // buffer flip, then coincident swap/frame_start/prefetch
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    wait_n(2);
    pulse_fs();
    chk("flip_fb_sel", fb_sel, DB);
    push_line(DB ? B1 : B0, 0);
    pulse_prefetch();
    drain("flip", 400);
    wait_n(10);
    c0 = n_cmd;
    push_line(B0, 0);
    swap_req = 1'b1;
    frame_start = 1'b1;
    prefetch_line = 1'b1;
    step();
    swap_req = 1'b0;
    frame_start = 1'b0;
    prefetch_line = 1'b0;
    chk("coincide_fb_sel", fb_sel, 0);
    drain("coincide", 400);
    wait_n(20);
    chk("coincide_cmds", 64'(n_cmd - c0), 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
